shift_dispatch: RTL and testbench

SHIFT_DISPATCH -- requirements
Module: shift_dispatch

---
 rtl/shift_dispatch.sv | 195 +++++++++++++++++++
 tb/tb_shift_dispatch.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/shift_dispatch.sv
// ---------------------------------------------------------------------------
// shift_dispatch
//
// Accepts one 16-bit left-shift request at a time, forwards the operand and
// the low four bits of the shift amount to an external registered LSL stage,
// collects that stage's result and holds it as a response until the consumer
// accepts it. Shift amounts of 16 or more never reach the LSL stage; they
// produce a zero result directly.
//
// Optional feature (compile-time macro SHIFT_DISPATCH_CARRY_EN):
//   defined   -> rsp_carry output present: last bit shifted out of the operand.
//   undefined -> rsp_carry port and its logic are absent.
//
// Ports:
//   clk              in   system clock, rising-edge active
//   rst              in   asynchronous, active-low reset
//   req_valid        in   request present
//   req_ready        out  block can accept a request (IDLE, out of reset)
//   req_data  [15:0] in   operand to shift left
//   req_shamt [15:0] in   unsigned shift amount
//   lsl_inp   [15:0] out  operand presented to the LSL stage
//   lsl_shift_value  out  shift amount presented to the LSL stage (0..15)
//   lsl_out   [15:0] in   LSL stage result, one edge after presentation
//   rsp_valid        out  response available
//   rsp_ready        in   consumer accepts the response
//   rsp_data  [15:0] out  shifted result
//   rsp_zero         out  rsp_data == 0
//   rsp_carry        out  last bit shifted out (macro builds only)
// ---------------------------------------------------------------------------
module shift_dispatch (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_data,
    input  logic [15:0] req_shamt,
    output logic [15:0] lsl_inp,
    output logic [15:0] lsl_shift_value,
    input  logic [15:0] lsl_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_zero
`ifdef SHIFT_DISPATCH_CARRY_EN
    ,
    output logic        rsp_carry
`endif
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t      state_q,     state_d;
    logic [15:0] lsl_inp_q,   lsl_inp_d;
    logic [3:0]  lsl_amt_q,   lsl_amt_d;
    logic        bypass_q,    bypass_d;     // captured: shamt >= 16
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q,  rsp_data_d;
    logic        rsp_zero_q,  rsp_zero_d;

`ifdef SHIFT_DISPATCH_CARRY_EN
    logic        carry_pend_q, carry_pend_d; // captured carry, published with the result
    logic        rsp_carry_q,  rsp_carry_d;
    logic        carry_calc;
    logic [3:0]  carry_idx;

    // Carry is the operand bit at position 16 - shamt for shamt 1..16.
    // Modulo 16 that index equals -shamt[3:0], which also gives bit 0 for
    // shamt == 16, so a 4-bit negate covers the whole valid range.
    always_comb begin
        carry_idx  = 4'd0 - req_shamt[3:0];
        carry_calc = 1'b0;
        if ((req_shamt != 16'd0) && (req_shamt <= 16'd16)) begin
            carry_calc = req_data[carry_idx];
        end
    end
`endif

    // req_ready is gated by rst so it reads 0 while reset is held, yet
    // rises as soon as reset releases so the very next edge can accept.
    assign req_ready       = rst && (state_q == IDLE);
    assign lsl_inp         = lsl_inp_q;
    assign lsl_shift_value = {12'h000, lsl_amt_q};
    assign rsp_valid       = rsp_valid_q;
    assign rsp_data        = rsp_data_q;
    assign rsp_zero        = rsp_zero_q;
`ifdef SHIFT_DISPATCH_CARRY_EN
    assign rsp_carry       = rsp_carry_q;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        lsl_inp_d   = lsl_inp_q;
        lsl_amt_d   = lsl_amt_q;
        bypass_d    = bypass_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
`ifdef SHIFT_DISPATCH_CARRY_EN
        carry_pend_d = carry_pend_q;
        rsp_carry_d  = rsp_carry_q;
`endif

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    bypass_d = |req_shamt[15:4];
`ifdef SHIFT_DISPATCH_CARRY_EN
                    carry_pend_d = carry_calc;
`endif
                    // Large shifts never drive the LSL stage, so its inputs
                    // keep the previously issued values.
                    if (~|req_shamt[15:4]) begin
                        lsl_inp_d = req_data;
                        lsl_amt_d = req_shamt[3:0];
                    end
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                if (bypass_q) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = 16'h0000;
                    rsp_zero_d  = 1'b1;
`ifdef SHIFT_DISPATCH_CARRY_EN
                    rsp_carry_d = carry_pend_q;
`endif
                end else begin
                    // The LSL stage samples its inputs on this edge.
                    state_d = CAPTURE;
                end
            end

            CAPTURE: begin
                state_d     = DONE;
                rsp_valid_d = 1'b1;
                rsp_data_d  = lsl_out;
                rsp_zero_d  = (lsl_out == 16'h0000);
`ifdef SHIFT_DISPATCH_CARRY_EN
                rsp_carry_d = carry_pend_q;
`endif
            end

            DONE: begin
                // Response fields stay frozen until the consumer takes them.
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // All state and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            lsl_inp_q   <= 16'h0000;
            lsl_amt_q   <= 4'h0;
            bypass_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_zero_q  <= 1'b0;
`ifdef SHIFT_DISPATCH_CARRY_EN
            carry_pend_q <= 1'b0;
            rsp_carry_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            lsl_inp_q   <= lsl_inp_d;
            lsl_amt_q   <= lsl_amt_d;
            bypass_q    <= bypass_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
`ifdef SHIFT_DISPATCH_CARRY_EN
            carry_pend_q <= carry_pend_d;
            rsp_carry_q  <= rsp_carry_d;
`endif
        end
    end

endmodule

// File: tb/tb_shift_dispatch.sv
// ---------------------------------------------------------------------------
// tb_shift_dispatch
//
// Directed, table-driven bench for shift_dispatch. A small behavioural model
// of the registered downstream LSL stage answers the DUT. Each table entry is
// issued, its latency, result and flags compared against hand-computed
// values, then acknowledged. Hand-written sequences cover reset values,
// first acceptance after reset and a reset pulse during CAPTURE.
// ---------------------------------------------------------------------------
module tb_shift_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_data;
    logic [15:0] req_shamt;
    logic [15:0] lsl_inp;
    logic [15:0] lsl_shift_value;
    logic [15:0] lsl_out = 16'h0000;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_zero;
`ifdef SHIFT_DISPATCH_CARRY_EN
    logic        rsp_carry;
`endif

    int total = 0;
    int bad   = 0;
    logic [15:0] last_inp = 16'h0000;   // last operand actually issued

    always #5 clk = ~clk;

    // Downstream registered LSL stage
    always @(posedge clk) lsl_out <= lsl_inp << lsl_shift_value[3:0];

    shift_dispatch dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_data        (req_data),
        .req_shamt       (req_shamt),
        .lsl_inp         (lsl_inp),
        .lsl_shift_value (lsl_shift_value),
        .lsl_out         (lsl_out),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_data        (rsp_data),
        .rsp_zero        (rsp_zero)
`ifdef SHIFT_DISPATCH_CARRY_EN
        ,
        .rsp_carry       (rsp_carry)
`endif
    );

    typedef struct {
        logic [15:0] data;
        logic [15:0] shamt;
        logic [15:0] exp_data;
        logic        exp_zero;
        logic        exp_carry;
        int          exp_lat;   // edges from acceptance to rsp_valid
        int          hold;      // cycles with rsp_ready low once valid
    } vec_t;

    vec_t vecs[12];

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check1 ({tag, "_req_ready"},  req_ready,       1'b0);
        check1 ({tag, "_rsp_valid"},  rsp_valid,       1'b0);
        check16({tag, "_rsp_data"},   rsp_data,        16'h0000);
        check1 ({tag, "_rsp_zero"},   rsp_zero,        1'b0);
        check16({tag, "_lsl_inp"},    lsl_inp,         16'h0000);
        check16({tag, "_lsl_shift"},  lsl_shift_value, 16'h0000);
`ifdef SHIFT_DISPATCH_CARRY_EN
        check1 ({tag, "_rsp_carry"},  rsp_carry,       1'b0);
`endif
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [15:0] prev_inp;
        int          lat;
        bit          got;
        prev_inp = last_inp;
        @(negedge clk);
        check1("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_data  = v.data;
        req_shamt = v.shamt;
        @(posedge clk);             // acceptance edge k
        #1;
        req_valid = 1'b0;
        req_data  = ~v.data;        // must be ignored after capture
        req_shamt = 16'h0003;
        @(negedge clk);
        check1("valid_in_issue", rsp_valid, 1'b0);
        check1("ready_busy",     req_ready, 1'b0);
        if (v.exp_lat == 2) begin
            check16("lsl_inp",   lsl_inp,         v.data);
            check16("lsl_shift", lsl_shift_value, {12'h000, v.shamt[3:0]});
            last_inp = v.data;
        end else begin
            check16("lsl_inp_kept", lsl_inp, prev_inp);
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 8) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (rsp_valid) got = 1'b1;
        end
        total++;
        if (!got || lat != v.exp_lat) begin
            bad++;
            $display("FAIL latency[%0d]: got %0d (valid=%b) expected %0d", idx, lat, got, v.exp_lat);
        end
        check16("rsp_data", rsp_data, v.exp_data);
        check1 ("rsp_zero", rsp_zero, v.exp_zero);
`ifdef SHIFT_DISPATCH_CARRY_EN
        check1 ("rsp_carry", rsp_carry, v.exp_carry);
`endif
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check1 ("hold_valid", rsp_valid, 1'b1);
            check16("hold_data",  rsp_data,  v.exp_data);
            check1 ("hold_zero",  rsp_zero,  v.exp_zero);
            check1 ("hold_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        check1("valid_after_hs", rsp_valid, 1'b0);
        check1("ready_after_hs", req_ready, 1'b1);
        $display("txn %0d: data=%h shamt=%h -> rsp=%h zero=%b lat=%0d hold=%0d",
                 idx, v.data, v.shamt, rsp_data, rsp_zero, lat, v.hold);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            data      shamt     exp_data  z     c     lat hold
        vecs[0]  = '{16'h000B, 16'h0001, 16'h0016, 1'b0, 1'b0, 2, 0};
        vecs[1]  = '{16'h0003, 16'h000F, 16'h8000, 1'b0, 1'b1, 2, 1};
        vecs[2]  = '{16'h0001, 16'h0010, 16'h0000, 1'b1, 1'b1, 1, 0};
        vecs[3]  = '{16'h0001, 16'h0100, 16'h0000, 1'b1, 1'b0, 1, 0};
        vecs[4]  = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 2, 5};
        vecs[5]  = '{16'h1234, 16'h0004, 16'h2340, 1'b0, 1'b1, 2, 0};
        vecs[6]  = '{16'hF000, 16'h0004, 16'h0000, 1'b1, 1'b1, 2, 0};
        vecs[7]  = '{16'h8001, 16'h0001, 16'h0002, 1'b0, 1'b1, 2, 0};
        vecs[8]  = '{16'hFFFF, 16'h0011, 16'h0000, 1'b1, 1'b0, 1, 2};
        vecs[9]  = '{16'hFFFE, 16'h0010, 16'h0000, 1'b1, 1'b0, 1, 0};
        vecs[10] = '{16'hA5A5, 16'h0008, 16'hA500, 1'b0, 1'b1, 2, 0};
        vecs[11] = '{16'h4000, 16'h0001, 16'h8000, 1'b0, 1'b0, 2, 0};

        rst       = 1'b0;
        req_valid = 1'b0;
        req_data  = 16'h0000;
        req_shamt = 16'h0000;
        rsp_ready = 1'b0;

        // Reset values while reset is held across clock edges
        #23;
        check_reset_outputs("por");

        // Release just after an edge; the next edge must be able to accept
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check1("ready_after_rst", req_ready, 1'b1);

        for (int i = 0; i < 12; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset pulse while a request sits in CAPTURE
        @(negedge clk);
        req_valid = 1'b1;
        req_data  = 16'h1234;
        req_shamt = 16'h0003;
        @(posedge clk);             // accept -> ISSUE
        #1;
        req_valid = 1'b0;
        @(posedge clk);             // ISSUE -> CAPTURE
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_capture");
        last_inp = 16'h0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        check1("valid_in_rst", rsp_valid, 1'b0);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check1("no_stale_rsp", rsp_valid, 1'b0);
            check1("idle_ready",   req_ready, 1'b1);
        end
        $display("txn rst: request 1234/3 discarded by reset during CAPTURE");

        begin
            vec_t v;
            v = '{16'h0030, 16'h0002, 16'h00C0, 1'b0, 1'b0, 2, 0};
            run_vec(v, 12);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
